// File: rtl/mips_multicycle_cu.sv
// mips_multicycle_cu: multi-cycle MIPS control FSM. It runs one micro-step per cycle
// and stretches the memory steps with a mem_ready handshake. A wait timeout abandons
// a stalled access, and the unit also produces illegal-instruction and retire pulses.
// Optional feature: define BNE_EN to decode bne (opcode 000101) into the BRANCH step.
module mips_multicycle_cu #(
  parameter int OPCODE_W  = 6,
  parameter int FUNCT_W   = 6,
  parameter int ALUCTRL_W = 3,
  parameter int WAIT_MAX  = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPCODE_W-1:0]  OpCode,
  input  logic [FUNCT_W-1:0]   func,
  input  logic                 mem_ready,
  output logic                 IorD,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 Branch,
  output logic                 Bne,
  output logic [1:0]           PCSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 RegDst,
  output logic                 MemtoReg,
  output logic                 RegWrite,
  output logic                 illegal,
  output logic                 mem_timeout,
  output logic                 retire
);

  // The counter only has to reach WAIT_MAX-1; the next low cycle is the timeout itself.
  localparam int CNT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(WAIT_MAX - 1);

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
`ifdef BNE_EN
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6'b000101);
`endif

  localparam logic [FUNCT_W-1:0] FN_ADD = FUNCT_W'(6'b100000);
  localparam logic [FUNCT_W-1:0] FN_SUB = FUNCT_W'(6'b100010);
  localparam logic [FUNCT_W-1:0] FN_AND = FUNCT_W'(6'b100100);
  localparam logic [FUNCT_W-1:0] FN_OR  = FUNCT_W'(6'b100101);
  localparam logic [FUNCT_W-1:0] FN_SLT = FUNCT_W'(6'b101010);

  localparam logic [ALUCTRL_W-1:0] ALU_ADD = ALUCTRL_W'(3'b010);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = ALUCTRL_W'(3'b110);
  localparam logic [ALUCTRL_W-1:0] ALU_AND = ALUCTRL_W'(3'b000);
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = ALUCTRL_W'(3'b001);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = ALUCTRL_W'(3'b111);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt, cnt_next;
  logic             in_mem;

  // State and wait-counter registers; reset drops straight back to FETCH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= cnt_next;
    end
  end

  // Next-state and control decode; the memory-step strobes wait for mem_ready.
  always_comb begin
    state_next  = state;
    cnt_next    = '0;
    in_mem      = 1'b0;
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    Branch      = 1'b0;
    Bne         = 1'b0;
    PCSrc       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b01;
    ALUControl  = ALU_ADD;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    illegal     = 1'b0;
    mem_timeout = 1'b0;
    retire      = 1'b0;

    case (state)
      S_FETCH: begin
        in_mem = 1'b1;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (OpCode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECUTE;
          OP_BEQ:       state_next = S_BRANCH;
`ifdef BNE_EN
          OP_BNE:       state_next = S_BRANCH;
`endif
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = (OpCode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD   = 1'b1;
        in_mem = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        IorD   = 1'b1;
        in_mem = 1'b1;
        if (mem_ready) begin
          MemWrite   = 1'b1;
          retire     = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b00;
        state_next = S_ALUWB;
        case (func)
          FN_ADD: ALUControl = ALU_ADD;
          FN_SUB: ALUControl = ALU_SUB;
          FN_AND: ALUControl = ALU_AND;
          FN_OR:  ALUControl = ALU_OR;
          FN_SLT: ALUControl = ALU_SLT;
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_ALUWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_SUB;
        PCSrc      = 2'b01;
        retire     = 1'b1;
        state_next = S_FETCH;
`ifdef BNE_EN
        if (OpCode == OP_BNE) Bne = 1'b1;
        else                  Branch = 1'b1;
`else
        Branch = 1'b1;
`endif
      end
      S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        PCSrc      = 2'b10;
        PCWrite    = 1'b1;
        retire     = 1'b1;
        state_next = S_FETCH;
      end
      default: begin
        illegal    = 1'b1;
        state_next = S_FETCH;
      end
    endcase

    // A stalled memory step counts its low cycles and gives up at the limit.
    if (in_mem && !mem_ready) begin
      if (wait_cnt == WAIT_LIMIT) begin
        mem_timeout = 1'b1;
        state_next  = S_FETCH;
      end else begin
        cnt_next = wait_cnt + CNT_W'(1);
      end
    end

    // Reset is combinationally forced onto every strobe so none can glitch high.
    if (rst) begin
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      Branch      = 1'b0;
      Bne         = 1'b0;
      RegWrite    = 1'b0;
      illegal     = 1'b0;
      mem_timeout = 1'b0;
      retire      = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_cu.sv
// tb_mips_multicycle_cu: randomized instruction stream against a step-plan model of the control unit.
module tb_mips_multicycle_cu;

  localparam int WAIT_MAX = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] OpCode, func;
  logic       mem_ready;
  logic       IorD, MemWrite, IRWrite, PCWrite, Branch, Bne;
  logic [1:0] PCSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic       RegDst, MemtoReg, RegWrite, illegal, mem_timeout, retire;

  mips_multicycle_cu #(
    .OPCODE_W(6), .FUNCT_W(6), .ALUCTRL_W(3), .WAIT_MAX(WAIT_MAX)
  ) dut (
    .clk(clk), .rst(rst), .OpCode(OpCode), .func(func), .mem_ready(mem_ready),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .Bne(Bne), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .illegal(illegal), .mem_timeout(mem_timeout), .retire(retire)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct packed {
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCWrite;
    logic       Branch;
    logic       Bne;
    logic [1:0] PCSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       illegal;
    logic       mem_timeout;
    logic       retire;
  } ctl_t;

  typedef struct packed {
    logic [63:0] name;
    logic        is_mem;
    ctl_t        exp;
    ctl_t        mask;
    ctl_t        rdy;
  } phase_t;

  ctl_t   obs;
  phase_t plan[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  assign obs = {IorD, MemWrite, IRWrite, PCWrite, Branch, Bne, PCSrc, ALUSrcA, ALUSrcB,
                ALUControl, RegDst, MemtoReg, RegWrite, illegal, mem_timeout, retire};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Strobes and pulses are checked in every step; mux selects only where the step defines them.
  function automatic phase_t newPhase(input logic [63:0] name, input logic is_mem);
    phase_t p;
    p.name = name;
    p.is_mem = is_mem;
    p.exp = '0;
    p.rdy = '0;
    p.mask = '0;
    p.mask.MemWrite = 1'b1; p.mask.IRWrite = 1'b1; p.mask.PCWrite = 1'b1;
    p.mask.Branch = 1'b1; p.mask.Bne = 1'b1; p.mask.RegWrite = 1'b1;
    p.mask.illegal = 1'b1; p.mask.mem_timeout = 1'b1; p.mask.retire = 1'b1;
    return p;
  endfunction

  function automatic phase_t withAlu(input phase_t p, input logic a, input logic [1:0] b, input logic [2:0] op);
    p.exp.ALUSrcA = a;     p.mask.ALUSrcA = 1'b1;
    p.exp.ALUSrcB = b;     p.mask.ALUSrcB = 2'b11;
    p.exp.ALUControl = op; p.mask.ALUControl = 3'b111;
    return p;
  endfunction

  function automatic phase_t withPcSrc(input phase_t p, input logic [1:0] v);
    p.exp.PCSrc = v; p.mask.PCSrc = 2'b11;
    return p;
  endfunction

  function automatic phase_t withIorD(input phase_t p, input logic v);
    p.exp.IorD = v; p.mask.IorD = 1'b1;
    return p;
  endfunction

  function automatic phase_t withWb(input phase_t p, input logic regdst, input logic memtoreg);
    p.exp.RegDst = regdst;     p.mask.RegDst = 1'b1;
    p.exp.MemtoReg = memtoreg; p.mask.MemtoReg = 1'b1;
    p.exp.RegWrite = 1'b1;
    p.exp.retire = 1'b1;
    return p;
  endfunction

  function automatic ctl_t fetchValues();
    phase_t p = newPhase("FETCH", 1'b1);
    p = withPcSrc(withIorD(withAlu(p, 1'b0, 2'b01, 3'b010), 1'b0), 2'b00);
    return p.exp;
  endfunction

  function automatic ctl_t fetchMask();
    phase_t p = newPhase("FETCH", 1'b1);
    p = withPcSrc(withIorD(withAlu(p, 1'b0, 2'b01, 3'b010), 1'b0), 2'b00);
    return p.mask;
  endfunction

  function automatic logic [3:0] aluForFunc(input logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b1010;
      6'b100010: return 4'b1110;
      6'b100100: return 4'b1000;
      6'b100101: return 4'b1001;
      6'b101010: return 4'b1111;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic logic isLegalOp(input logic [5:0] op);
    case (op)
      6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
`ifdef BNE_EN
      6'b000101: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Cycles from fetch to retire with no wait states; 0 means the instruction never retires.
  function automatic int expLatency(input logic [5:0] op, input logic [5:0] fn);
    logic [3:0] a = aluForFunc(fn);
    case (op)
      6'b100011: return 5;
      6'b101011: return 4;
      6'b000000: return a[3] ? 4 : 0;
      6'b000100: return 3;
`ifdef BNE_EN
      6'b000101: return 3;
`endif
      6'b001000: return 4;
      6'b000010: return 3;
      default:   return 0;
    endcase
  endfunction

  // Expand one instruction into its sequence of micro-steps.
  task automatic buildPlan(input logic [5:0] op, input logic [5:0] fn);
    phase_t p;
    logic [3:0] a;
    plan.delete();
    p = newPhase("FETCH", 1'b1);
    p = withPcSrc(withIorD(withAlu(p, 1'b0, 2'b01, 3'b010), 1'b0), 2'b00);
    p.rdy.IRWrite = 1'b1;
    p.rdy.PCWrite = 1'b1;
    plan.push_back(p);
    p = withAlu(newPhase("DECODE", 1'b0), 1'b0, 2'b11, 3'b010);
    if (!isLegalOp(op)) begin
      p.exp.illegal = 1'b1;
      plan.push_back(p);
      return;
    end
    plan.push_back(p);
    if (op == 6'b100011 || op == 6'b101011) begin
      plan.push_back(withAlu(newPhase("MEMADR", 1'b0), 1'b1, 2'b10, 3'b010));
      if (op == 6'b100011) begin
        plan.push_back(withIorD(newPhase("MEMRD", 1'b1), 1'b1));
        plan.push_back(withWb(newPhase("MEMWB", 1'b0), 1'b0, 1'b1));
      end else begin
        p = withIorD(newPhase("MEMWR", 1'b1), 1'b1);
        p.rdy.MemWrite = 1'b1;
        p.rdy.retire = 1'b1;
        plan.push_back(p);
      end
    end else if (op == 6'b000000) begin
      a = aluForFunc(fn);
      p = withAlu(newPhase("EXECUTE", 1'b0), 1'b1, 2'b00, a[2:0]);
      p.exp.illegal = !a[3];
      plan.push_back(p);
      if (a[3]) plan.push_back(withWb(newPhase("ALUWB", 1'b0), 1'b1, 1'b0));
    end else if (op == 6'b001000) begin
      plan.push_back(withAlu(newPhase("ADDIEX", 1'b0), 1'b1, 2'b10, 3'b010));
      plan.push_back(withWb(newPhase("ADDIWB", 1'b0), 1'b0, 1'b0));
    end else if (op == 6'b000010) begin
      p = withPcSrc(newPhase("JUMP", 1'b0), 2'b10);
      p.exp.PCWrite = 1'b1;
      p.exp.retire = 1'b1;
      plan.push_back(p);
    end else begin
      p = withPcSrc(withAlu(newPhase("BRANCH", 1'b0), 1'b1, 2'b00, 3'b110), 2'b01);
      p.exp.Bne = (op == 6'b000101);
      p.exp.Branch = (op != 6'b000101);
      p.exp.retire = 1'b1;
      plan.push_back(p);
    end
  endtask

  function automatic int pickLows();
    int r = $urandom_range(0, 9);
    if (r <= 3 || r == 9) return 0;
    if (r <= 6) return $urandom_range(1, 3);
    if (r == 7) return WAIT_MAX - 1;
    return WAIT_MAX;
  endfunction

  // Run one instruction. Entry and exit are 1 time unit after a rising edge.
  // force_lows >= 0 fixes the wait count of non-fetch memory steps; abort_at >= 0 pulses reset in that step.
  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input int force_lows, input int abort_at);
    int cycles = 0, waits = 0, ret_cycle = -1, lows, w;
    logic ready, timed_out = 1'b0;
    phase_t p;
    ctl_t e;
    buildPlan(op, fn);
    OpCode = op;
    func = fn;
    for (int idx = 0; idx < plan.size() && !timed_out; idx++) begin
      p = plan[idx];
      lows = 0;
      if (p.is_mem) lows = (force_lows < 0) ? pickLows() : ((idx == 0) ? 0 : force_lows);
      w = 0;
      while (1) begin
        ready = p.is_mem ? (w >= lows) : 1'($urandom_range(0, 1));
        mem_ready = ready;
        e = p.exp;
        if (p.is_mem && ready) e = e | p.rdy;
        if (p.is_mem && !ready && w == WAIT_MAX - 1) e.mem_timeout = 1'b1;
        @(negedge clk);
        checkOutput($sformatf("%s", p.name), 32'(obs & p.mask), 32'(e));
        cycles++;
        if (retire === 1'b1 && ret_cycle < 0) ret_cycle = cycles;
        if (idx == abort_at) begin
          mem_ready = 1'b1;
          #1 rst = 1'b1;
          #1 checkOutput("reset_mid", 32'(obs & fetchMask()), 32'(fetchValues()));
          @(posedge clk);
          #1 checkOutput("reset_hold", 32'(obs & fetchMask()), 32'(fetchValues()));
          rst = 1'b0;
          return;
        end
        @(posedge clk);
        #1;
        if (e.mem_timeout) begin
          timed_out = 1'b1;
          break;
        end
        if (!p.is_mem || ready) break;
        w++;
        waits++;
      end
    end
    if (timed_out || expLatency(op, fn) == 0)
      checkOutput("no_retire", 32'(ret_cycle), 32'hFFFF_FFFF);
    else
      checkOutput("latency", 32'(ret_cycle), 32'(expLatency(op, fn) + waits));
  endtask

  function automatic logic [5:0] randomOp(output logic [5:0] fn);
    logic [5:0] ops[8];
    logic [5:0] fns[5];
    logic [5:0] op;
    ops[0] = 6'b100011; ops[1] = 6'b101011; ops[2] = 6'b000000; ops[3] = 6'b000100;
    ops[4] = 6'b001000; ops[5] = 6'b000010; ops[6] = 6'b000101; ops[7] = 6'($urandom);
    fns[0] = 6'b100000; fns[1] = 6'b100010; fns[2] = 6'b100100; fns[3] = 6'b100101; fns[4] = 6'b101010;
    op = ops[$urandom_range(0, 7)];
    fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
    return op;
  endfunction

  initial begin
    logic [5:0] op, fn;
    rst = 1'b1;
    mem_ready = 1'b1;
    OpCode = 6'b000000;
    func = 6'b100000;
    @(negedge clk);
    checkOutput("reset", 32'(obs & fetchMask()), 32'(fetchValues()));
    @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(6'b000000, 6'b100000, 0, 2);
    applyStimulus(6'b000000, 6'b100000, 0, -1);
    applyStimulus(6'b100011, 6'b000000, 3, -1);
    applyStimulus(6'b101011, 6'b000000, WAIT_MAX, -1);
    applyStimulus(6'b100011, 6'b000000, WAIT_MAX - 1, -1);
    applyStimulus(6'b000100, 6'b000000, 0, -1);
    applyStimulus(6'b000010, 6'b000000, 0, -1);
    applyStimulus(6'b111111, 6'b000000, 0, -1);
    applyStimulus(6'b000000, 6'b000111, 0, -1);
    applyStimulus(6'b000101, 6'b000000, 0, -1);
    applyStimulus(6'b001000, 6'b000000, 0, -1);

    for (int i = 0; i < 300; i++) begin
      op = randomOp(fn);
      applyStimulus(op, fn, -1, ($urandom_range(0, 24) == 0) ? 1 : -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_cu.md
Name: mips_multicycle_cu

Overview:
- Parametrised, clocked successor to the single-cycle control unit.
- Drives a multi-cycle MIPS datapath (shared instruction/data memory, IR, A/B/ALUOut registers) through a Moore FSM, one micro-step per cycle.
- Adds memory wait-state handshake, per-access wait timeout, illegal-instruction detection and a retire pulse.
- Sits between the instruction register and the datapath muxes/enables.

Parameters:
- OPCODE_W, 6, opcode field width
- FUNCT_W, 6, funct field width
- ALUCTRL_W, 3, ALUControl width
- WAIT_MAX, 15, max consecutive mem_ready-low cycles in a memory state before timeout (≥1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- OpCode  in  OPCODE_W  IR[31:26]
- func  in  FUNCT_W  IR[5:0]
- mem_ready  in  1  memory completes access this cycle
- IorD  out  1  0=PC addresses memory, 1=ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  load IR
- PCWrite  out  1  unconditional PC load
- Branch  out  1  PC load if ALU zero
- Bne  out  1  PC load if ALU not-zero (0 without BNE_EN)
- PCSrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- ALUControl  out  ALUCTRL_W  ALU operation
- RegDst  out  1  1=rd, 0=rt
- MemtoReg  out  1  1=memory data, 0=ALUOut
- RegWrite  out  1  register file write
- illegal  out  1  one-cycle pulse: unsupported opcode/funct
- mem_timeout  out  1  one-cycle pulse: wait limit hit
- retire  out  1  one-cycle pulse: instruction completes this cycle

Behaviour:
- Reset: state=FETCH, wait counter=0. All strobes/pulses low while rst=1 (IRWrite, PCWrite, MemWrite, RegWrite, Branch, Bne, illegal, mem_timeout, retire). Other outputs hold FETCH values.
- ALU codes: ADD=010, SUB=110, AND=000, OR=001, SLT=111.
- Outputs are a pure function of state. Exceptions: ALUControl in EXECUTE decodes func; strobes in memory states are gated by mem_ready.
- FETCH:
  - IorD=0, ALUSrcA=0, ALUSrcB=01, ADD, PCSrc=00.
  - IRWrite=PCWrite=mem_ready.
  - mem_ready=1 -> DECODE; else stay.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ADD (branch target into ALUOut).
  - Next state by OpCode: 100011/101011 -> MEMADR; 000000 -> EXECUTE; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP.
  - Any other opcode -> FETCH with illegal=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. lw -> MEMRD, sw -> MEMWR.
- MEMRD: IorD=1. mem_ready=1 -> MEMWB; else stay.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, retire=1 -> FETCH.
- MEMWR: IorD=1, MemWrite=mem_ready. mem_ready=1 -> FETCH with retire=1.
- EXECUTE:
  - ALUSrcA=1, ALUSrcB=00.
  - func decode: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT -> ALUWB.
  - Other func: ALUControl=ADD, illegal=1, -> FETCH (no RegWrite).
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, retire=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01, Branch=1, retire=1 -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD -> ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, retire=1 -> FETCH.
- JUMP: PCSrc=10, PCWrite=1, retire=1 -> FETCH.
- Latency without waits: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3 cycles. Each memory-state wait cycle adds 1.
- Wait counter:
  - Counts consecutive cycles with mem_ready=0 in FETCH/MEMRD/MEMWR.
  - Clears on mem_ready=1 and on state exit.
  - When the count reaches WAIT_MAX and mem_ready is still 0, mem_timeout pulses, the counter clears, and the FSM goes to FETCH (from FETCH: restart fetch).
  - An abandoned access never asserts RegWrite/MemWrite/retire.
- mem_ready=1 in the same cycle the limit would be reached: the access completes normally, no timeout.
- Async rst mid-instruction: immediate return to FETCH. No strobe may glitch high during reset.
- Unused state encodings -> FETCH next cycle, illegal=1.

Optional Feature:
- Macro BNE_EN.
- Defined: DECODE maps opcode 000101 -> BRANCH. In BRANCH, Bne=1 and Branch=0 for bne; Branch=1 and Bne=0 for beq. Latency 3.
- Undefined: Bne tied 0; opcode 000101 is illegal (pulse, -> FETCH).

Test Plan:
- rst high mid-EXECUTE, release; add (OpCode 000000, func 100000), mem_ready=1 -> FETCH, DECODE, EXECUTE(ALUControl=010), ALUWB(RegWrite=1, RegDst=1, retire=1); 4 cycles.
- lw 100011 with mem_ready low 3 cycles in MEMRD -> MEMRD held 3 extra cycles, IorD=1; MEMWB RegWrite=1, MemtoReg=1 on cycle 8.
- sw 101011, WAIT_MAX=15, mem_ready held 0 in MEMWR -> mem_timeout on the 15th wait cycle, MemWrite never 1, next state FETCH, retire=0.
- beq 000100 -> BRANCH: ALUControl=110, Branch=1, PCSrc=01; j 000010 -> PCWrite=1, PCSrc=10; each 3 cycles.
- Opcode 111111 -> illegal pulse in DECODE cycle, back in FETCH. func 000111 in EXECUTE -> illegal, RegWrite stays 0.
- Opcode 000101: with BNE_EN -> Bne=1, Branch=0; without BNE_EN -> illegal=1, Bne=0.
